// File: rtl/bridge2xheep_pkg.sv
// Shared definitions for the CW305 -> X-HEEP loader register front end.
// Holds the host register map, the STATUS bit positions, the 32-bit word
// type and a byte-lane select helper.
package bridge2xheep_pkg;

    typedef logic [31:0] word_t;

    // Host register offsets
    localparam logic [7:0] REG_ADDR   = 8'h00;
    localparam logic [7:0] REG_INSTR  = 8'h01;
    localparam logic [7:0] REG_STATUS = 8'h02;
    localparam logic [7:0] REG_LEVEL  = 8'h03;
    localparam logic [7:0] REG_WCNT   = 8'h04;

    // STATUS bit positions
    localparam int unsigned ST_BUSY      = 0;
    localparam int unsigned ST_ADDR_PEND = 1;
    localparam int unsigned ST_EMPTY     = 2;
    localparam int unsigned ST_FULL      = 3;
    localparam int unsigned ST_OVF       = 4;

    // Byte lane of a word (lane 0 = LSB)
    function automatic logic [7:0] byte_sel(input word_t w, input logic [1:0] lane);
        return w[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/bridge2xheep_instr_fifo.sv
// Synchronous instruction FIFO with a registered head word.
// Ports: clk/rst_n; push + wdata (write side); pop (read side, ignored when
// empty); full, empty, level, head (registered); empty_nxt_c (empty flag as
// it will be after this edge); push_ok_c (push accepted this cycle).
// A push while full is accepted only when a pop happens in the same cycle.
module bridge2xheep_instr_fifo
    import bridge2xheep_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  word_t            wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level,
    output word_t            head,
    output logic             empty_nxt_c,
    output logic             push_ok_c
);

    word_t             mem_q [DEPTH];
    word_t             mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  rd_nxt;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    word_t             head_q, head_d;
    logic              pop_ok;
    logic              push_ok;

    // Next-state: pointers, storage, level flags and head word
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        rd_nxt   = rd_ptr_q + PTR_W'(1);
        pop_ok   = pop & ~empty_q;
        push_ok  = push & (~full_q | pop_ok);

        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_nxt;
        end

        level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
        empty_d = (level_d == '0);
        full_d  = (level_d == LVL_W'(DEPTH));

        // Head tracks the oldest entry; an incoming word becomes head when
        // the queue is (or is about to be) otherwise empty.
        if (push_ok && (empty_q || (pop_ok && level_q == LVL_W'(1)))) begin
            head_d = wdata;
        end else if (pop_ok && level_q > LVL_W'(1)) begin
            head_d = mem_q[rd_nxt];
        end else if (pop_ok) begin
            head_d = '0;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            head_q   <= head_d;
        end
    end

    assign full        = full_q;
    assign empty       = empty_q;
    assign level       = level_q;
    assign head        = head_q;
    assign empty_nxt_c = empty_d;
    assign push_ok_c   = push_ok;

endmodule

// File: rtl/bridge2xheep_regs.sv
// Host-side register front end of the CW305 -> X-HEEP loader.
// Assembles byte-wide host writes into a 32-bit load address and instruction
// words, queues instructions in a FIFO and hands both to the control unit,
// which retires them with active-low clear pulses.
// Ports: clk, rst_n (async active-low); host side reg_address/reg_bytecnt/
// reg_datai/reg_write/reg_read/reg_datao; control side busy,
// rst_new_addr_valid, rst_instr_valid, addr_valid/addr_data,
// instr_valid/instr_data.
// Build option: define BRIDGE_REGS_WCNT_EN to add the 32-bit accepted-push
// counter at offset 0x04; without it 0x04 reads 0.
module bridge2xheep_regs
    import bridge2xheep_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter word_t       RST_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  reg_address,
    input  logic [1:0]  reg_bytecnt,
    input  logic [7:0]  reg_datai,
    output logic [7:0]  reg_datao,
    input  logic        reg_write,
    input  logic        reg_read,
    input  logic        busy,
    input  logic        rst_new_addr_valid,
    input  logic        rst_instr_valid,
    output logic        addr_valid,
    output logic [31:0] addr_data,
    output logic        instr_valid,
    output logic [31:0] instr_data
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    word_t             addr_stage_q, addr_stage_d;
    word_t             instr_stage_q, instr_stage_d;
    word_t             addr_data_q, addr_data_d;
    logic              addr_pend_q, addr_pend_d;
    logic              addr_valid_q, addr_valid_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        reg_datao_q, reg_datao_d;
    word_t             reg_word_c;
    word_t             wcnt_word;

    logic              wr_addr, wr_instr, wr_status;
    logic              addr_commit, fifo_push, fifo_pop, fifo_push_ok;
    logic              fifo_full, fifo_empty, fifo_empty_nxt;
    logic [LVL_W-1:0]  fifo_level;
    word_t             fifo_head;

    // Host write decode; lane 3 commits the staged word
    assign wr_addr     = reg_write && (reg_address == REG_ADDR);
    assign wr_instr    = reg_write && (reg_address == REG_INSTR);
    assign wr_status   = reg_write && (reg_address == REG_STATUS);
    assign addr_commit = wr_addr && (reg_bytecnt == 2'd3);
    assign fifo_push   = wr_instr && (reg_bytecnt == 2'd3);
    assign fifo_pop    = ~rst_instr_valid;

    bridge2xheep_instr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (fifo_push),
        .wdata       (instr_stage_d),
        .pop         (fifo_pop),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .level       (fifo_level),
        .head        (fifo_head),
        .empty_nxt_c (fifo_empty_nxt),
        .push_ok_c   (fifo_push_ok)
    );

    // Read-side register view
    always_comb begin
        reg_word_c = '0;
        case (reg_address)
            REG_ADDR:   reg_word_c = addr_data_q;
            REG_STATUS: begin
                reg_word_c[ST_BUSY]      = busy;
                reg_word_c[ST_ADDR_PEND] = addr_pend_q;
                reg_word_c[ST_EMPTY]     = fifo_empty;
                reg_word_c[ST_FULL]      = fifo_full;
                reg_word_c[ST_OVF]       = ovf_q;
            end
            REG_LEVEL:  reg_word_c = 32'(fifo_level);
            REG_WCNT:   reg_word_c = wcnt_word;
            default:    reg_word_c = '0;
        endcase
    end

    // Staging, address handshake, overflow flag and read-back byte
    always_comb begin
        addr_stage_d  = addr_stage_q;
        instr_stage_d = instr_stage_q;
        addr_data_d   = addr_data_q;
        addr_pend_d   = addr_pend_q;
        ovf_d         = ovf_q;
        reg_datao_d   = reg_datao_q;

        if (wr_addr) addr_stage_d[{reg_bytecnt, 3'b000} +: 8] = reg_datai;
        if (wr_instr) instr_stage_d[{reg_bytecnt, 3'b000} +: 8] = reg_datai;

        // A commit in the same cycle as the clear pulse keeps the address pending
        if (!rst_new_addr_valid) addr_pend_d = 1'b0;
        if (addr_commit) begin
            addr_data_d = addr_stage_d;
            addr_pend_d = 1'b1;
        end

        if (wr_status) begin
            ovf_d = 1'b0;
        end else if (fifo_push && !fifo_push_ok) begin
            ovf_d = 1'b1;
        end

        // Address is only offered once queued words have drained
        addr_valid_d = addr_pend_d & fifo_empty_nxt;

        if (reg_read) reg_datao_d = byte_sel(reg_word_c, reg_bytecnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_stage_q  <= '0;
            instr_stage_q <= '0;
            addr_data_q   <= RST_ADDR;
            addr_pend_q   <= 1'b0;
            addr_valid_q  <= 1'b0;
            ovf_q         <= 1'b0;
            reg_datao_q   <= '0;
        end else begin
            addr_stage_q  <= addr_stage_d;
            instr_stage_q <= instr_stage_d;
            addr_data_q   <= addr_data_d;
            addr_pend_q   <= addr_pend_d;
            addr_valid_q  <= addr_valid_d;
            ovf_q         <= ovf_d;
            reg_datao_q   <= reg_datao_d;
        end
    end

`ifdef BRIDGE_REGS_WCNT_EN
    // Accepted-push counter; any write to its offset clears it
    word_t wcnt_q, wcnt_d;

    always_comb begin
        wcnt_d = wcnt_q;
        if (reg_write && (reg_address == REG_WCNT)) begin
            wcnt_d = '0;
        end else if (fifo_push_ok) begin
            wcnt_d = wcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt_q <= '0;
        else        wcnt_q <= wcnt_d;
    end

    assign wcnt_word = wcnt_q;
`else
    assign wcnt_word = '0;
`endif

    assign reg_datao   = reg_datao_q;
    assign addr_valid  = addr_valid_q;
    assign addr_data   = addr_data_q;
    assign instr_valid = ~fifo_empty;
    assign instr_data  = fifo_head;

endmodule

// File: tb/tb_bridge2xheep_regs.sv
// Directed self-checking bench for bridge2xheep_regs (FIFO_DEPTH = 8).
module tb_bridge2xheep_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  reg_address;
    logic [1:0]  reg_bytecnt;
    logic [7:0]  reg_datai;
    logic [7:0]  reg_datao;
    logic        reg_write;
    logic        reg_read;
    logic        busy;
    logic        rst_new_addr_valid;
    logic        rst_instr_valid;
    logic        addr_valid;
    logic [31:0] addr_data;
    logic        instr_valid;
    logic [31:0] instr_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    bridge2xheep_regs #(
        .FIFO_DEPTH (8),
        .RST_ADDR   (32'h0)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .reg_address        (reg_address),
        .reg_bytecnt        (reg_bytecnt),
        .reg_datai          (reg_datai),
        .reg_datao          (reg_datao),
        .reg_write          (reg_write),
        .reg_read           (reg_read),
        .busy               (busy),
        .rst_new_addr_valid (rst_new_addr_valid),
        .rst_instr_valid    (rst_instr_valid),
        .addr_valid         (addr_valid),
        .addr_data          (addr_data),
        .instr_valid        (instr_valid),
        .instr_data         (instr_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr_byte(input logic [7:0] a, input logic [1:0] l, input logic [7:0] d);
        @(negedge clk);
        reg_address = a; reg_bytecnt = l; reg_datai = d; reg_write = 1'b1;
        @(negedge clk);
        reg_write = 1'b0;
    endtask

    task automatic wr_word(input logic [7:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) wr_byte(a, 2'(i), w[8*i +: 8]);
    endtask

    task automatic rd_byte(input logic [7:0] a, input logic [1:0] l, output logic [7:0] d);
        @(negedge clk);
        reg_address = a; reg_bytecnt = l; reg_read = 1'b1;
        @(negedge clk);
        reg_read = 1'b0;
        d = reg_datao;
    endtask

    task automatic rd_word(input logic [7:0] a, output logic [31:0] w);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            rd_byte(a, 2'(i), b);
            w[8*i +: 8] = b;
        end
    endtask

    task automatic pop_pulse();
        @(negedge clk); rst_instr_valid = 1'b0;
        @(negedge clk); rst_instr_valid = 1'b1;
    endtask

    task automatic clr_addr_pulse();
        @(negedge clk); rst_new_addr_valid = 1'b0;
        @(negedge clk); rst_new_addr_valid = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; reg_address = '0; reg_bytecnt = '0; reg_datai = '0;
        reg_write = 1'b0; reg_read = 1'b0; busy = 1'b0;
        rst_new_addr_valid = 1'b1; rst_instr_valid = 1'b1;

        // Reset values
        #12;
        check("rst_datao", 32'(reg_datao), 32'h0);
        check("rst_addr_valid", 32'(addr_valid), 32'h0);
        check("rst_addr_data", addr_data, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_instr_data", instr_data, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Address assembly: only lane 3 commits
        wr_byte(8'h00, 2'd0, 8'h00);
        wr_byte(8'h00, 2'd1, 8'h01);
        wr_byte(8'h00, 2'd2, 8'h00);
        check("addr_valid_pre_lane3", 32'(addr_valid), 32'h0);
        wr_byte(8'h00, 2'd3, 8'h80);
        check("addr_data_commit", addr_data, 32'h8000_0100);
        check("addr_valid_commit", 32'(addr_valid), 32'h1);
        rd_word(8'h00, rd);
        check("addr_readback", rd, 32'h8000_0100);
        busy = 1'b1;
        rd_byte(8'h02, 2'd0, rd[7:0]);
        check("status_busy_pend_empty", 32'(rd[7:0]), 32'h07);
        busy = 1'b0;
        clr_addr_pulse();
        check("addr_valid_cleared", 32'(addr_valid), 32'h0);

        // Single instruction, then pop
        wr_byte(8'h01, 2'd0, 8'h13);
        wr_byte(8'h01, 2'd1, 8'h00);
        wr_byte(8'h01, 2'd2, 8'h00);
        check("instr_valid_pre_lane3", 32'(instr_valid), 32'h0);
        wr_byte(8'h01, 2'd3, 8'h00);
        check("instr_valid_commit", 32'(instr_valid), 32'h1);
        check("instr_data_commit", instr_data, 32'h0000_0013);
        pop_pulse();
        check("instr_valid_popped", 32'(instr_valid), 32'h0);
        rd_word(8'h03, rd);
        check("level_after_pop", rd, 32'h0);
        pop_pulse();
        check("pop_on_empty_ignored", 32'(instr_valid), 32'h0);

        // Overflow: nine commits into depth 8
        for (int i = 0; i < 9; i++) wr_word(8'h01, 32'h100 + 32'(i));
        rd_word(8'h03, rd);
        check("level_full", rd, 32'h8);
        rd_byte(8'h02, 2'd0, rd[7:0]);
        check("status_full_ovf", 32'(rd[7:0]), 32'h18);
        check("head_first", instr_data, 32'h100);
        wr_byte(8'h02, 2'd0, 8'h00);
        rd_byte(8'h02, 2'd0, rd[7:0]);
        check("status_ovf_cleared", 32'(rd[7:0]), 32'h08);
        pop_pulse();
        check("head_second", instr_data, 32'h101);
        for (int i = 0; i < 6; i++) pop_pulse();
        check("head_last_kept", instr_data, 32'h107);
        pop_pulse();
        check("ninth_dropped", 32'(instr_valid), 32'h0);

        // Address held off while instructions drain
        wr_word(8'h01, 32'hA);
        wr_word(8'h01, 32'hB);
        wr_word(8'h00, 32'h0000_1000);
        check("addr_gated", 32'(addr_valid), 32'h0);
        check("addr_gated_data", addr_data, 32'h0000_1000);
        pop_pulse();
        check("addr_gated_one_left", 32'(addr_valid), 32'h0);
        check("head_B", instr_data, 32'hB);
        pop_pulse();
        check("addr_released", 32'(addr_valid), 32'h1);

        // Commit coincident with clear pulse: commit wins
        wr_byte(8'h00, 2'd0, 8'h00);
        wr_byte(8'h00, 2'd1, 8'h20);
        wr_byte(8'h00, 2'd2, 8'h00);
        @(negedge clk);
        reg_address = 8'h00; reg_bytecnt = 2'd3; reg_datai = 8'h00;
        reg_write = 1'b1; rst_new_addr_valid = 1'b0;
        @(negedge clk);
        reg_write = 1'b0; rst_new_addr_valid = 1'b1;
        check("commit_wins_valid", 32'(addr_valid), 32'h1);
        check("commit_wins_data", addr_data, 32'h0000_2000);
        clr_addr_pulse();
        check("commit_wins_cleared", 32'(addr_valid), 32'h0);

        // Full FIFO, push with same-cycle pop
        for (int i = 0; i < 8; i++) wr_word(8'h01, 32'h200 + 32'(i));
        wr_byte(8'h01, 2'd0, 8'h08);
        wr_byte(8'h01, 2'd1, 8'h02);
        wr_byte(8'h01, 2'd2, 8'h00);
        @(negedge clk);
        reg_address = 8'h01; reg_bytecnt = 2'd3; reg_datai = 8'h00;
        reg_write = 1'b1; rst_instr_valid = 1'b0;
        @(negedge clk);
        reg_write = 1'b0; rst_instr_valid = 1'b1;
        rd_byte(8'h02, 2'd0, rd[7:0]);
        check("full_pushpop_no_ovf", 32'(rd[7:0]), 32'h08);
        rd_word(8'h03, rd);
        check("full_pushpop_level", rd, 32'h8);
        check("full_pushpop_head", instr_data, 32'h201);
        wr_word(8'h00, 32'h0000_3000);
        check("addr_pending_fifo_busy", 32'(addr_valid), 32'h0);
        rd_byte(8'h02, 2'd0, rd[7:0]);
        check("status_pend_full", 32'(rd[7:0]), 32'h0A);

        // Asynchronous reset mid-stream
        @(negedge clk); #2 rst_n = 1'b0; #1;
        check("midrst_datao", 32'(reg_datao), 32'h0);
        check("midrst_addr_valid", 32'(addr_valid), 32'h0);
        check("midrst_addr_data", addr_data, 32'h0);
        check("midrst_instr_valid", 32'(instr_valid), 32'h0);
        check("midrst_instr_data", instr_data, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        rd_byte(8'h02, 2'd0, rd[7:0]);
        check("midrst_status", 32'(rd[7:0]), 32'h04);

        // Word counter and unmapped offsets
        wr_byte(8'h04, 2'd0, 8'hFF);
        wr_word(8'h01, 32'h1);
        wr_word(8'h01, 32'h2);
        wr_word(8'h01, 32'h3);
        rd_word(8'h04, rd);
`ifdef BRIDGE_REGS_WCNT_EN
        check("wcnt_three", rd, 32'h3);
`else
        check("wcnt_absent", rd, 32'h0);
`endif
        wr_byte(8'h04, 2'd2, 8'h00);
        rd_word(8'h04, rd);
        check("wcnt_cleared", rd, 32'h0);
        rd_word(8'h03, rd);
        check("level_three", rd, 32'h3);
        wr_word(8'h05, 32'hFFFF_FFFF);
        rd_word(8'h05, rd);
        check("unmapped_reads_zero", rd, 32'h0);
        rd_word(8'h01, rd);
        check("instr_reads_zero", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
